// File: rtl/ex_branch_latch.sv
// Execute-side consumer of the decode/execute latch.
// Resolves beq/bne/j/jr, drives a registered flush/redirect back to fetch and
// decode, registers memory/writeback control into EX/MEM, squashes the single
// wrong-path instruction after a taken transfer, and holds a sticky halt.
module ex_branch_latch #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_en,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] rdat1_i,
  input  logic [ADDR_W-1:0] rdat2_i,
  input  logic [ADDR_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] laddr_i,
  input  logic [ADDR_W-1:0] pc4_i,
  input  logic              beq_i,
  input  logic              bne_i,
  input  logic              jsig_i,
  input  logic              jrsig_i,
  input  logic              dREN_i,
  input  logic              dWEN_i,
  input  logic              reg_wr_i,
  input  logic              halt_i,
  input  logic [REG_W-1:0]  wsel_i,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              valid_o,
  output logic              dREN_o,
  output logic              dWEN_o,
  output logic              reg_wr_o,
  output logic [REG_W-1:0]  wsel_o,
  output logic [ADDR_W-1:0] stdat_o,
  output logic              halt_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Next-cycle values of every registered output.
  logic              flush_nxt;
  logic              redirect_valid_nxt;
  logic [ADDR_W-1:0] redirect_pc_nxt;
  logic              valid_nxt;
  logic              dren_nxt;
  logic              dwen_nxt;
  logic              reg_wr_nxt;
  logic [REG_W-1:0]  wsel_nxt;
  logic [ADDR_W-1:0] stdat_nxt;
  logic              halt_nxt;

  // Branch resolution, purely combinational on the decode latch contents.
  logic              eq;
  logic              taken;
  logic [ADDR_W-1:0] target;

  // PC-relative target: the immediate is already sign-extended, so a plain
  // modular add of the word-scaled offset gives the right two's-complement result.
  function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] pc4,
                                                   input logic [ADDR_W-1:0] imm);
    logic signed [ADDR_W-1:0] off;
    off = $signed(imm) <<< 2;
    return pc4 + $unsigned(off);
  endfunction

  assign eq     = (rdat1_i == rdat2_i);
  assign taken  = jrsig_i | jsig_i | (beq_i & eq) | (bne_i & ~eq);
  assign target = jrsig_i ? rdat1_i :
                  jsig_i  ? laddr_i :
                            rel_target(pc4_i, imm_i);

  // State register; reset is asynchronous so it lands even mid-squash.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next outputs; a held stage keeps everything but the pulses.
  always_comb begin
    state_nxt          = state;
    flush_nxt          = 1'b0;
    redirect_valid_nxt = 1'b0;
    redirect_pc_nxt    = redirect_pc;
    valid_nxt          = valid_o;
    dren_nxt           = dREN_o;
    dwen_nxt           = dWEN_o;
    reg_wr_nxt         = reg_wr_o;
    wsel_nxt           = wsel_o;
    stdat_nxt          = stdat_o;
    halt_nxt           = halt_o;

    if (ex_en) begin
      // Default for an accepting edge is a bubble; only a live RUN instruction
      // overrides it.
      valid_nxt  = 1'b0;
      dren_nxt   = 1'b0;
      dwen_nxt   = 1'b0;
      reg_wr_nxt = 1'b0;
      wsel_nxt   = wsel_i;
      stdat_nxt  = rdat2_i;

      case (state)
        RUN: begin
          if (valid_i) begin
            if (halt_i) begin
              // Halt wins over any transfer bit: no redirect, nothing retires.
              halt_nxt  = 1'b1;
              state_nxt = HALTED;
            end else begin
              valid_nxt  = 1'b1;
              dren_nxt   = dREN_i;
              dwen_nxt   = dWEN_i;
              reg_wr_nxt = reg_wr_i;
              if (taken) begin
                flush_nxt          = 1'b1;
                redirect_valid_nxt = 1'b1;
                redirect_pc_nxt    = target;
                state_nxt          = SQUASH;
              end
            end
          end
        end
        SQUASH: begin
          // The instruction accepted now was fetched down the wrong path.
          state_nxt = RUN;
        end
        HALTED: begin
          halt_nxt = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // EX/MEM latch and redirect outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      valid_o        <= 1'b0;
      dREN_o         <= 1'b0;
      dWEN_o         <= 1'b0;
      reg_wr_o       <= 1'b0;
      wsel_o         <= '0;
      stdat_o        <= '0;
      halt_o         <= 1'b0;
    end else begin
      flush          <= flush_nxt;
      redirect_valid <= redirect_valid_nxt;
      redirect_pc    <= redirect_pc_nxt;
      valid_o        <= valid_nxt;
      dREN_o         <= dren_nxt;
      dWEN_o         <= dwen_nxt;
      reg_wr_o       <= reg_wr_nxt;
      wsel_o         <= wsel_nxt;
      stdat_o        <= stdat_nxt;
      halt_o         <= halt_nxt;
    end
  end

endmodule

// File: tb/tb_ex_branch_latch.sv
// Bench for ex_branch_latch: directed scenarios followed by random traffic,
// all checked against a behavioural model of the execute stage.
module tb_ex_branch_latch;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ex_en, valid_i;
  logic [ADDR_W-1:0] rdat1_i, rdat2_i, imm_i, laddr_i, pc4_i;
  logic              beq_i, bne_i, jsig_i, jrsig_i;
  logic              dREN_i, dWEN_i, reg_wr_i, halt_i;
  logic [REG_W-1:0]  wsel_i;
  logic              flush, redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              valid_o, dREN_o, dWEN_o, reg_wr_o, halt_o;
  logic [REG_W-1:0]  wsel_o;
  logic [ADDR_W-1:0] stdat_o;

  int tests = 0;
  int fails = 0;

  // Behavioural model: "the next accepted instruction is discarded" and
  // "the machine has stopped" flags, plus the expected output values.
  bit                m_discard_next;
  bit                m_stopped;
  logic              e_flush, e_rv, e_valid, e_dren, e_dwen, e_regwr, e_halt;
  logic [ADDR_W-1:0] e_rpc, e_stdat;
  logic [REG_W-1:0]  e_wsel;

  ex_branch_latch #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ex_en(ex_en), .valid_i(valid_i),
    .rdat1_i(rdat1_i), .rdat2_i(rdat2_i), .imm_i(imm_i), .laddr_i(laddr_i),
    .pc4_i(pc4_i), .beq_i(beq_i), .bne_i(bne_i), .jsig_i(jsig_i),
    .jrsig_i(jrsig_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i), .reg_wr_i(reg_wr_i),
    .halt_i(halt_i), .wsel_i(wsel_i), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .valid_o(valid_o), .dREN_o(dREN_o), .dWEN_o(dWEN_o), .reg_wr_o(reg_wr_o),
    .wsel_o(wsel_o), .stdat_o(stdat_o), .halt_o(halt_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_discard_next = 0; m_stopped = 0;
    e_flush = 0; e_rv = 0; e_rpc = '0; e_valid = 0; e_dren = 0; e_dwen = 0;
    e_regwr = 0; e_halt = 0; e_wsel = '0; e_stdat = '0;
  endtask

  // Apply the spec rules to the inputs present at the edge just taken.
  task automatic model_edge();
    bit tk;
    e_flush = 0;
    e_rv    = 0;
    if (!ex_en) return;
    e_valid = 0; e_dren = 0; e_dwen = 0; e_regwr = 0;
    if (m_stopped) return;
    if (m_discard_next) begin
      m_discard_next = 0;
      return;
    end
    if (!valid_i) return;
    if (halt_i) begin
      m_stopped = 1;
      e_halt    = 1;
      return;
    end
    e_valid = 1; e_dren = dREN_i; e_dwen = dWEN_i; e_regwr = reg_wr_i;
    e_wsel  = wsel_i; e_stdat = rdat2_i;
    tk = jrsig_i || jsig_i || (beq_i && rdat1_i == rdat2_i) || (bne_i && rdat1_i != rdat2_i);
    if (tk) begin
      e_flush = 1; e_rv = 1; m_discard_next = 1;
      if (jrsig_i)     e_rpc = rdat1_i;
      else if (jsig_i) e_rpc = laddr_i;
      else             e_rpc = 32'(pc4_i + imm_i * 4);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
    chk({tag, ".rv"},    32'(redirect_valid), 32'(e_rv));
    chk({tag, ".rpc"},   redirect_pc, e_rpc);
    chk({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
    chk({tag, ".dren"},  32'(dREN_o), 32'(e_dren));
    chk({tag, ".dwen"},  32'(dWEN_o), 32'(e_dwen));
    chk({tag, ".regwr"}, 32'(reg_wr_o), 32'(e_regwr));
    chk({tag, ".halt"},  32'(halt_o), 32'(e_halt));
    if (e_valid) begin
      chk({tag, ".wsel"},  32'(wsel_o), 32'(e_wsel));
      chk({tag, ".stdat"}, stdat_o, e_stdat);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic clear_in();
    ex_en = 1; valid_i = 1; rdat1_i = 0; rdat2_i = 0; imm_i = 0; laddr_i = 0;
    pc4_i = 0; beq_i = 0; bne_i = 0; jsig_i = 0; jrsig_i = 0; dREN_i = 0;
    dWEN_i = 0; reg_wr_i = 0; halt_i = 0; wsel_i = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    nRST = 0;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ".wsel"},  32'(wsel_o), 32'(e_wsel));
    chk({tag, ".stdat"}, stdat_o, e_stdat);
    @(negedge CLK);
    nRST = 1;
  endtask

  initial begin
    clear_in();
    model_reset();
    nRST = 0;
    repeat (2) @(posedge CLK);
    do_reset("reset");

    // Taken beq, then asynchronous reset 3 ns after the edge.
    clear_in();
    beq_i = 1; rdat1_i = 7; rdat2_i = 7; pc4_i = 32'h104; imm_i = 32'hFFFF_FFFC;
    reg_wr_i = 1; wsel_i = 5'd3;
    tick("rst_mid.beq");
    #2 nRST = 0;
    #1;
    model_reset();
    check_all("rst_mid.async");
    @(negedge CLK) nRST = 1;
    clear_in();
    reg_wr_i = 1; wsel_i = 5'd9; rdat2_i = 32'h55;
    tick("rst_mid.after");

    // beq taken, wrong-path squash, then a normal instruction.
    clear_in();
    beq_i = 1; rdat1_i = 7; rdat2_i = 7; pc4_i = 32'h104; imm_i = 32'hFFFF_FFFC;
    tick("beq.taken");
    chk("beq.rpc_const", redirect_pc, 32'h0000_00F4);
    clear_in();
    reg_wr_i = 1; wsel_i = 5'd4;
    tick("beq.squashed");
    chk("beq.squash_regwr", 32'(reg_wr_o), 32'd0);
    tick("beq.next_ok");
    chk("beq.next_regwr", 32'(reg_wr_o), 32'd1);

    // bne not taken: no squash of the follower.
    clear_in();
    bne_i = 1; rdat1_i = 5; rdat2_i = 5;
    tick("bne.nt");
    clear_in();
    dREN_i = 1; reg_wr_i = 1; wsel_i = 5'd7;
    tick("bne.follow");

    // jr and j both set: register target wins.
    clear_in();
    jrsig_i = 1; jsig_i = 1; rdat1_i = 32'h2000; laddr_i = 32'h400;
    tick("jr.prio");
    chk("jr.rpc_const", redirect_pc, 32'h0000_2000);
    clear_in();
    tick("jr.squash");

    // Taken jump then a 3-cycle stall: single-cycle pulses, squash persists.
    clear_in();
    jsig_i = 1; laddr_i = 32'h0000_0800; dWEN_i = 1; rdat2_i = 32'hBEEF;
    tick("stall.j");
    clear_in();
    ex_en = 0; dWEN_i = 1;
    for (int i = 0; i < 3; i++) tick("stall.hold");
    ex_en = 1;
    tick("stall.squash");
    tick("stall.resume");

    // Halt with a taken beq: halt wins, later stores are suppressed.
    clear_in();
    halt_i = 1; beq_i = 1; rdat1_i = 1; rdat2_i = 1; pc4_i = 32'h40; imm_i = 32'h10;
    tick("halt.beq");
    clear_in();
    dWEN_i = 1;
    for (int i = 0; i < 3; i++) tick("halt.sticky");
    chk("halt.dwen_const", 32'(dWEN_o), 32'd0);
    do_reset("halt.reset");

    // Random traffic with periodic resets.
    for (int n = 0; n < 400; n++) begin
      int kind;
      if (n % 80 == 79) do_reset("rand.reset");
      ex_en    = ($urandom % 4) != 0;
      valid_i  = ($urandom % 8) != 0;
      rdat1_i  = $urandom % 4;
      rdat2_i  = ($urandom % 2) ? rdat1_i : $urandom;
      imm_i    = $urandom;
      laddr_i  = $urandom;
      pc4_i    = $urandom;
      kind     = $urandom % 6;
      beq_i    = (kind == 0) || (kind == 5);
      bne_i    = (kind == 1);
      jsig_i   = (kind == 2) || (kind == 4);
      jrsig_i  = (kind == 3) || (kind == 4);
      dREN_i   = $urandom % 2;
      dWEN_i   = $urandom % 2;
      reg_wr_i = $urandom % 2;
      halt_i   = ($urandom % 50) == 0;
      wsel_i   = REG_W'($urandom);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_branch_latch.md
Name: ex_branch_latch

Overview:
- Execute-side consumer of the decode/execute pipeline latch.
- Takes operands and control from the decode latch outputs and resolves beq/bne/j/jr.
- Drives the registered flush and redirect PC back to fetch and the decode latch.
- Registers memory and writeback control into an EX/MEM stage, squashes the one wrong-path instruction after a taken transfer, and enforces sticky halt.

Parameters:
- ADDR_W, 32, width of PC, operand and immediate paths
- REG_W, 5, register-select width

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ex_en  in  1  stage advance; low = hold
- valid_i  in  1  decode latch carries a real instruction
- rdat1_i  in  ADDR_W  rs operand
- rdat2_i  in  ADDR_W  rt operand / store data
- imm_i  in  ADDR_W  sign-extended immediate
- laddr_i  in  ADDR_W  precomputed jump target
- pc4_i  in  ADDR_W  PC+4 of the instruction
- beq_i, bne_i, jsig_i, jrsig_i  in  1 each  transfer type
- dREN_i, dWEN_i, reg_wr_i, halt_i  in  1 each  control
- wsel_i  in  REG_W  destination register
- flush  out  1  one-cycle pulse; clears the decode latch
- redirect_valid  out  1  one-cycle pulse; fetch loads redirect_pc
- redirect_pc  out  ADDR_W  transfer target
- valid_o, dREN_o, dWEN_o, reg_wr_o  out  1 each  EX/MEM control
- wsel_o  out  REG_W  EX/MEM destination
- stdat_o  out  ADDR_W  store data
- halt_o  out  1  sticky halt

Behaviour:
- Reset (async, nRST=0):
  - All outputs 0, redirect_pc 0, state RUN.
  - Takes effect immediately, also mid-squash or mid-pulse.
- States: RUN, SQUASH, HALTED. Only edges with ex_en=1 accept an instruction.
- ex_en=0:
  - EX/MEM outputs and state hold.
  - flush and redirect_valid are forced 0 at that edge. Pulses never stretch.
- RUN, ex_en=1, valid_i=1:
  - Capture dREN/dWEN/reg_wr/wsel/rdat2 into the EX/MEM outputs. valid_o=1.
  - eq = (rdat1_i == rdat2_i).
  - taken = jrsig_i | jsig_i | (beq_i & eq) | (bne_i & ~eq).
  - Target priority: jrsig → rdat1_i; else jsig → laddr_i; else pc4_i + (imm_i << 2), truncated mod 2^ADDR_W.
  - On taken, at the same edge: flush=1, redirect_valid=1, redirect_pc=target, next state SQUASH. The branch's own controls still register.
  - If halt_i=1: halt_o=1, valid_o=0, dREN/dWEN/reg_wr=0, next state HALTED. No redirect even if a transfer bit is set; halt has priority.
- RUN, ex_en=1, valid_i=0:
  - Bubble: valid_o and all enables 0. No redirect.
- SQUASH, ex_en=1:
  - The accepted instruction is wrong-path. Output valid_o=0 and all enables 0, regardless of valid_i or halt_i. No redirect.
  - Next state RUN.
  - Flush/redirect deassert after their single cycle.
- SQUASH with ex_en=0: stays in SQUASH until the next accepting edge.
- HALTED:
  - Absorbing until reset. halt_o=1. valid_o and enables 0. No redirects.
- Latency: redirect one cycle after the accepting edge. EX/MEM outputs register at the accepting edge.

Test Plan:
- Reset mid-pulse: taken beq, then nRST low 3 ns after the edge → all outputs 0 at once; state RUN after release.
- beq taken: pc4_i=0x0000_0104, imm_i=0xFFFF_FFFC, rdat1=rdat2=7, ex_en=1 → flush=redirect_valid=1 for one cycle, redirect_pc=0x0000_00F4.
  - Next accepted instruction has reg_wr_i=1 → reg_wr_o=0, valid_o=0.
  - Following instruction passes normally.
- bne not taken: rdat1=rdat2=5 → no flush. Next instruction is not squashed.
- jr with jsig also set: rdat1=0x0000_2000, laddr=0x0000_0400 → redirect_pc=0x0000_2000 (jr priority).
- Stall: taken jump, then ex_en=0 for 3 cycles → pulses last exactly 1 cycle, outputs hold, SQUASH persists. At the first ex_en=1, that instruction is squashed.
- Halt: halt_i=1 with beq taken → halt_o=1, no redirect. Later valid dWEN_i=1 instructions give dWEN_o=0 until nRST.
